// File: rtl/btn_cmd_gen.sv
// btn_cmd_gen: push-button front end for the image-generation controller.
// Synchronises and debounces five buttons, auto-repeats the direction
// buttons, arbitrates simultaneous events (C > U > D > L > R) and issues
// one-cycle key_en* pulses through a single pending slot that honours busy.
module btn_cmd_gen #(
  parameter int DB_CYCLES     = 250000,
  parameter int REPEAT_DELAY  = 10000000,
  parameter int REPEAT_PERIOD = 3750000,
  parameter int CNT_W         = 24
) (
  input  logic pixelclk,
  input  logic reset_n,
  input  logic btnC,
  input  logic btnU,
  input  logic btnD,
  input  logic btnL,
  input  logic btnR,
  input  logic busy,
  output logic key_enC,
  output logic key_enU,
  output logic key_enD,
  output logic key_enL,
  output logic key_enR,
  output logic key_pending
);

  // Button vector order: bit 4 = C, 3 = U, 2 = D, 1 = L, 0 = R.
  localparam int NB = 5;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_DLY  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_PER  = CNT_W'(REPEAT_PERIOD - 1);

  // Fixed-priority one-hot pick, highest bit wins.
  function automatic logic [NB-1:0] pick_first(input logic [NB-1:0] req);
    logic [NB-1:0] gnt;
    gnt = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (req[i] && (gnt == '0)) gnt[i] = 1'b1;
    end
    return gnt;
  endfunction

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync_p0;
  logic [NB-1:0]    sync_p1;
  logic [NB-1:0]    db;
  logic [NB-1:0]    db_prev;
  logic [CNT_W-1:0] db_cnt [NB];
  logic [NB-1:0]    press;
  logic [3:0]       dir_press;
  logic [3:0]       new_owner;
  logic [3:0]       owner;
  logic [CNT_W-1:0] rpt_timer;
  logic             owner_held;
  logic             rpt_fire;
  logic [NB-1:0]    events;
  logic [NB-1:0]    winner;
  logic             slot_vld;
  logic [NB-1:0]    slot_key;
  logic             issue;
  logic [NB-1:0]    key_en_p2;

  assign raw = {btnC, btnU, btnD, btnL, btnR};

  // Two-flop synchroniser per raw button.
  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: accept a new level only after DB_CYCLES consecutive mismatches.
  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      db      <= '0;
      db_prev <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      db_prev <= db;
      for (int i = 0; i < NB; i++) begin
        if (sync_p1[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= ~db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // ---- stage p1: press / repeat events and arbitration ----
  assign press      = db & ~db_prev;
  assign dir_press  = press[3:0];
  assign owner_held = |(owner & db[3:0]);
  assign rpt_fire   = owner_held && (rpt_timer == '0);
  assign events     = press | {1'b0, (rpt_fire ? owner : 4'b0000)};
  assign winner     = pick_first(events);

  // New repeat owner: highest-priority direction pressed this cycle.
  always_comb begin
    new_owner = '0;
    if (dir_press[3])      new_owner[3] = 1'b1;
    else if (dir_press[2]) new_owner[2] = 1'b1;
    else if (dir_press[1]) new_owner[1] = 1'b1;
    else if (dir_press[0]) new_owner[0] = 1'b1;
  end

  // Shared repeat timer: a press takes ownership, release of the owner stops it.
  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      owner     <= '0;
      rpt_timer <= '0;
    end else if (|dir_press) begin
      owner     <= new_owner;
      rpt_timer <= RPT_DLY;
    end else if ((owner != '0) && !owner_held) begin
      owner     <= '0;
      rpt_timer <= '0;
    end else if (rpt_fire) begin
      rpt_timer <= RPT_PER;
    end else if (owner != '0) begin
      rpt_timer <= rpt_timer - 1'b1;
    end
  end

  // ---- stage p2: pending slot and registered command pulses ----
  assign issue = slot_vld && !busy;

  // Single pending slot; it may be refilled on the edge it issues.
  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      slot_vld  <= 1'b0;
      slot_key  <= '0;
      key_en_p2 <= '0;
    end else begin
      key_en_p2 <= issue ? slot_key : '0;
      if ((winner != '0) && (!slot_vld || issue)) begin
        slot_vld <= 1'b1;
        slot_key <= winner;
      end else if (issue) begin
        slot_vld <= 1'b0;
      end
    end
  end

  assign key_enC     = key_en_p2[4];
  assign key_enU     = key_en_p2[3];
  assign key_enD     = key_en_p2[2];
  assign key_enL     = key_en_p2[1];
  assign key_enR     = key_en_p2[0];
  assign key_pending = slot_vld;

endmodule

// File: tb/tb_btn_cmd_gen.sv
// Directed bench for btn_cmd_gen with DB_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Expected pulses are queued with the edge they follow;
// a monitor compares every cycle's key_en vector against the queue.
module tb_btn_cmd_gen;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int LAT = DB + 3;  // edge of first raw sample -> edge that raises key_en

  localparam logic [4:0] K_C = 5'b10000;
  localparam logic [4:0] K_U = 5'b01000;
  localparam logic [4:0] K_D = 5'b00100;
  localparam logic [4:0] K_L = 5'b00010;
  localparam logic [4:0] K_R = 5'b00001;

  logic pixelclk = 1'b0;
  logic reset_n, busy;
  logic btnC, btnU, btnD, btnL, btnR;
  logic key_enC, key_enU, key_enD, key_enL, key_enR, key_pending;

  typedef struct {
    int         cyc;
    logic [4:0] key;
  } exp_t;

  exp_t       sb[$];
  int         edge_cnt = 0;
  int         tests = 0;
  int         fails = 0;
  logic [4:0] obs_v, exp_v;

  btn_cmd_gen #(
    .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(24)
  ) dut (
    .pixelclk(pixelclk), .reset_n(reset_n),
    .btnC(btnC), .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .busy(busy),
    .key_enC(key_enC), .key_enU(key_enU), .key_enD(key_enD),
    .key_enL(key_enL), .key_enR(key_enR), .key_pending(key_pending)
  );

  always #5 pixelclk = ~pixelclk;

  always @(posedge pixelclk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input int cyc, input logic [4:0] key);
    sb.push_back('{cyc, key});
  endtask

  task automatic wait_until(input int c);
    while (edge_cnt < c) @(negedge pixelclk);
  endtask

  // Scoreboard monitor: every cycle the pulse vector must equal the queued
  // expectation for this edge, or all-zero when none is due.
  always @(posedge pixelclk) begin
    #1;
    obs_v = {key_enC, key_enU, key_enD, key_enL, key_enR};
    exp_v = '0;
    if (sb.size() > 0 && sb[0].cyc == edge_cnt) begin
      exp_v = sb[0].key;
      void'(sb.pop_front());
    end
    check($sformatf("pulse@%0d", edge_cnt), {27'd0, obs_v}, {27'd0, exp_v});
  end

  initial begin
    int n, t, b, p0, r;
    reset_n = 1'b0; busy = 1'b0;
    btnC = 1'b0; btnU = 1'b0; btnD = 1'b0; btnL = 1'b0; btnR = 1'b0;
    repeat (3) @(negedge pixelclk);
    check("reset_pending", {31'd0, key_pending}, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge pixelclk);

    // Bouncing U is ignored; the final steady press gives a single pulse.
    for (int i = 0; i < 10; i++) begin
      btnU = (i % 2 == 0);
      repeat (2) @(negedge pixelclk);
    end
    btnU = 1'b1;
    n = edge_cnt + 1;
    expect_pulse(n + LAT, K_U);
    wait_until(n + 10);
    btnU = 1'b0;
    wait_until(n + 50);

    // Auto-repeat on R: press, first repeat after 20, then every 8.
    btnR = 1'b1;
    n = edge_cnt + 1;
    t = n + LAT;
    expect_pulse(t, K_R);
    for (int k = 0; k < 5; k++) expect_pulse(t + RD + k * RP, K_R);
    wait_until(t + 49);
    btnR = 1'b0;
    wait_until(t + 130);

    // C held long: no repeat.
    btnC = 1'b1;
    n = edge_cnt + 1;
    expect_pulse(n + LAT, K_C);
    wait_until(n + 100);
    btnC = 1'b0;
    wait_until(n + 130);

    // C and L together: C wins, L is dropped.
    btnC = 1'b1; btnL = 1'b1;
    n = edge_cnt + 1;
    expect_pulse(n + LAT, K_C);
    wait_until(n + 9);
    btnC = 1'b0; btnL = 1'b0;
    wait_until(n + 60);

    // Busy back-pressure: U waits in the slot, D is dropped.
    busy = 1'b1;
    b = edge_cnt + 1;
    wait_until(b + 1);
    btnU = 1'b1;
    n = edge_cnt + 1;
    expect_pulse(b + 40, K_U);
    wait_until(n + 7);
    check("pending_after_u", {31'd0, key_pending}, 32'd1);
    btnU = 1'b0;
    wait_until(n + 9);
    btnD = 1'b1;
    wait_until(n + 16);
    check("pending_after_d", {31'd0, key_pending}, 32'd1);
    wait_until(n + 17);
    btnD = 1'b0;
    wait_until(n + 25);
    check("pending_late", {31'd0, key_pending}, 32'd1);
    wait_until(b + 39);
    busy = 1'b0;
    wait_until(b + 41);
    check("pending_cleared", {31'd0, key_pending}, 32'd0);
    wait_until(b + 80);

    // Reset mid-repeat on L, L held throughout.
    btnL = 1'b1;
    n = edge_cnt + 1;
    p0 = n + LAT;
    expect_pulse(p0, K_L);
    expect_pulse(p0 + RD, K_L);
    wait_until(p0 + 22);
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge pixelclk);
      check($sformatf("rst_keys_%0d", k),
            {27'd0, key_enC, key_enU, key_enD, key_enL, key_enR}, 32'd0);
      check($sformatf("rst_pending_%0d", k), {31'd0, key_pending}, 32'd0);
    end
    reset_n = 1'b1;
    r = edge_cnt + 1;
    expect_pulse(r + LAT, K_L);
    expect_pulse(r + LAT + RD, K_L);
    wait_until(r + 24);
    btnL = 1'b0;
    wait_until(r + 80);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_cmd_gen.md
# btn_cmd_gen

Front-end command generator between the board push-buttons and the image-generation controller. Synchronises and debounces the five raw buttons, adds auto-repeat on the four direction buttons, arbitrates simultaneous presses and issues one-cycle `key_en*` command pulses. Holds at most one pending command while the controller signals busy. Runs entirely in the 25 MHz pixel clock domain.

## Interface

Parameters:
- `DB_CYCLES`, 250000: consecutive stable cycles required to accept a level change (10 ms at 25 MHz).
- `REPEAT_DELAY`, 10000000: cycles from press event to first repeat (400 ms).
- `REPEAT_PERIOD`, 3750000: cycles between subsequent repeats (150 ms).
- `CNT_W`, 24: counter width; must hold the largest of the three parameters.

Ports:
- `pixelclk`  in  1: single clock, 25 MHz.
- `reset_n`  in  1: synchronous, active-low reset.
- `btnC`, `btnU`, `btnD`, `btnL`, `btnR`  in  1 each: raw asynchronous buttons, active high.
- `busy`  in  1: controller cannot accept a command this cycle.
- `key_enC`, `key_enU`, `key_enD`, `key_enL`, `key_enR`  out  1 each: registered one-cycle command pulses; at most one high per cycle.
- `key_pending`  out  1: pending slot occupied.

## Operation

- **Synchroniser:** two flops per button, reset to 0.
- **Debounce:** each button has a stable level `db` (reset 0) and a counter (reset 0).
  - If the second sync stage differs from `db`, the counter increments. Otherwise the counter clears.
  - On the edge where the counter would reach `DB_CYCLES`, `db` toggles and the counter clears.
- **Press event:** a 0→1 transition of `db`. Releases generate no event.
- **Auto-repeat:** a single shared timer with an owner register (none, U, D, L, R); reset is none.
  - A direction press event makes that button the owner and loads the timer.
  - While the owner's `db` is high, a repeat event fires exactly `REPEAT_DELAY` cycles after the press event, then every `REPEAT_PERIOD` cycles.
  - A new direction press transfers ownership and restarts the delay. The previous button stops repeating even if still held.
  - When the owner's `db` falls, owner becomes none and the timer stops.
  - C never repeats and never affects ownership.
- **Arbitration:** press and repeat events from the same cycle are resolved with priority C > U > D > L > R. Losers are dropped, not queued.
- **Pending slot:** one entry, reset empty.
  - The arbitration winner loads the slot only if the slot is empty, or is being emptied on the same edge.
  - Otherwise the winner is dropped. Nothing is buffered behind a busy controller.
- **Issue:** on an edge where the slot is valid and `busy` is low, the matching `key_en*` is registered high for exactly one cycle and the slot clears.
  - On that same edge the slot may reload with a new winner.
  - `key_pending` reflects slot state.

## Timing

- All outputs reset to 0. Reset clears synchronisers, `db`, counters, timer, owner and slot.
- Reset mid-hold aborts any repeat. A button still held after reset is re-debounced from 0 and produces a fresh press event.
- Latency: raw input first sampled high at edge N with `busy` low gives a `key_en*` pulse high in the cycle after edge N+DB_CYCLES+3. Total is DB_CYCLES+4 cycles: 2 sync, DB_CYCLES debounce, 1 slot load, 1 issue.
- Repeat pulses keep the same latency, so pulse spacing equals event spacing.
- `busy` is sampled on the issue edge only. A pulse is never cut or stretched by a later change of `busy`.
- Counters saturate-free: parameters must be ≥ 2 and fit in `CNT_W`.

## Test plan

Use `DB_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.

- **Debounce:** `btnU` toggles every 2 cycles for 20 cycles, then stays high from cycle N → exactly one `key_enU` pulse, at cycle N+8. No other pulses.
- **Auto-repeat:** `btnR` held 60 cycles after its press pulse at cycle T → `key_enR` at T, T+20, T+28, T+36, T+44, T+52. No pulse after release.
- **No repeat on C, and simultaneous press:** `btnC` held 100 cycles → a single `key_enC`. `btnC` and `btnL` rising in the same cycle → `key_enC` only, never `key_enL`.
- **Busy back-pressure:** `busy` high for 40 cycles; press U, then 10 cycles later D →
  - `key_pending`=1 while `busy` is high.
  - `key_enU` pulses the cycle after the first edge sampling `busy`=0.
  - D is dropped and `key_enD` never asserts.
- **Reset mid-repeat:** `reset_n` low for 3 cycles while `btnL` is repeating, with L held throughout →
  - All outputs are 0 during reset.
  - Next `key_enL` arrives 8 cycles after `reset_n` returns high.
  - Its first repeat follows 20 cycles later.
